// File: rtl/coord_rotate_scan.sv
// coord_rotate_scan: raster-order destination scan with inverse rotation about
// the image centre. Trig values are Q1.8 (256 = 1.0) and are latched on an
// accepted start. A 3-stage pipeline streams source coordinates out over
// valid/ready. A single enable (output not valid, or downstream ready) freezes
// every stage and the raster counters together.
module coord_rotate_scan #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CX    = IMG_W / 2,
    parameter int CY    = IMG_H / 2,
    parameter int CW    = 12,
    parameter int TW    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [TW-1:0] sin_val,
    input  logic signed [TW-1:0] cos_val,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [CW-1:0] dst_x,
    output logic        [CW-1:0] dst_y,
    output logic signed [CW-1:0] src_x,
    output logic signed [CW-1:0] src_y,
    output logic                 in_range,
    output logic                 out_last
);

    localparam int PW   = CW + TW;      // product width
    localparam int SW   = PW + 1;       // sum width
    localparam int FRAC = 8;            // Q1.8 fraction bits

    localparam logic        [CW-1:0] XMAX = CW'(IMG_W - 1);
    localparam logic        [CW-1:0] YMAX = CW'(IMG_H - 1);
    localparam logic signed [CW-1:0] CX_S = CW'(CX);
    localparam logic signed [CW-1:0] CY_S = CW'(CY);
    localparam logic signed [CW-1:0] W_S  = CW'(IMG_W);
    localparam logic signed [CW-1:0] H_S  = CW'(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic        [CW-1:0] x_q;
    logic        [CW-1:0] y_q;
    logic signed [TW-1:0] sin_q;
    logic signed [TW-1:0] cos_q;

    // Stage 1: centred coordinates
    logic                 v1_q,    v1_d;
    logic signed [CW-1:0] dx1_q,   dx1_d;
    logic signed [CW-1:0] dy1_q,   dy1_d;
    logic        [CW-1:0] dstx1_q, dstx1_d;
    logic        [CW-1:0] dsty1_q, dsty1_d;
    logic                 last1_q, last1_d;

    // Stage 2: products
    logic                 v2_q,    v2_d;
    logic signed [PW-1:0] pxc2_q,  pxc2_d;
    logic signed [PW-1:0] pys2_q,  pys2_d;
    logic signed [PW-1:0] pxs2_q,  pxs2_d;
    logic signed [PW-1:0] pyc2_q,  pyc2_d;
    logic        [CW-1:0] dstx2_q, dstx2_d;
    logic        [CW-1:0] dsty2_q, dsty2_d;
    logic                 last2_q, last2_d;

    // Stage 3: output registers
    logic                 ov_q,    ov_d;
    logic        [CW-1:0] dstx3_q, dstx3_d;
    logic        [CW-1:0] dsty3_q, dsty3_d;
    logic signed [CW-1:0] srcx3_q, srcx3_d;
    logic signed [CW-1:0] srcy3_q, srcy3_d;
    logic                 ir3_q,   ir3_d;
    logic                 last3_q, last3_d;

    logic signed [SW-1:0] sum_x;
    logic signed [SW-1:0] sum_y;

    logic en;
    logic issue;
    logic last_pix;
    logic out_hs;

    assign en       = !ov_q || out_ready;
    assign issue    = (state_q == RUN) && en;
    assign last_pix = (x_q == XMAX) && (y_q == YMAX);
    assign out_hs   = ov_q && out_ready;

    // Control FSM, raster counters and trig latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sin_q   <= sin_val;
                        cos_q   <= cos_val;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (last_pix) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= DRAIN;
                        end else if (x_q == XMAX) begin
                            x_q <= '0;
                            y_q <= y_q + CW'(1);
                        end else begin
                            x_q <= x_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs && last3_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next-state values for all three pipeline stages
    always_comb begin
        v1_d    = issue;
        dx1_d   = $signed(x_q) - CX_S;
        dy1_d   = $signed(y_q) - CY_S;
        dstx1_d = x_q;
        dsty1_d = y_q;
        last1_d = last_pix;

        v2_d    = v1_q;
        pxc2_d  = PW'(dx1_q) * PW'(cos_q);
        pys2_d  = PW'(dy1_q) * PW'(sin_q);
        pxs2_d  = PW'(dx1_q) * PW'(sin_q);
        pyc2_d  = PW'(dy1_q) * PW'(cos_q);
        dstx2_d = dstx1_q;
        dsty2_d = dsty1_q;
        last2_d = last1_q;

        sum_x   = SW'(pxc2_q) + SW'(pys2_q);
        sum_y   = SW'(pyc2_q) - SW'(pxs2_q);
        ov_d    = v2_q;
        dstx3_d = dstx2_q;
        dsty3_d = dsty2_q;
        srcx3_d = CW'(sum_x >>> FRAC) + CX_S;
        srcy3_d = CW'(sum_y >>> FRAC) + CY_S;
        ir3_d   = !srcx3_d[CW-1] && (srcx3_d < W_S) &&
                  !srcy3_d[CW-1] && (srcy3_d < H_S);
        last3_d = last2_q;
    end

    // Pipeline registers; every stage advances only on the shared enable
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            dx1_q   <= '0;
            dy1_q   <= '0;
            dstx1_q <= '0;
            dsty1_q <= '0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            pxc2_q  <= '0;
            pys2_q  <= '0;
            pxs2_q  <= '0;
            pyc2_q  <= '0;
            dstx2_q <= '0;
            dsty2_q <= '0;
            last2_q <= 1'b0;
            ov_q    <= 1'b0;
            dstx3_q <= '0;
            dsty3_q <= '0;
            srcx3_q <= '0;
            srcy3_q <= '0;
            ir3_q   <= 1'b0;
            last3_q <= 1'b0;
        end else if (en) begin
            v1_q    <= v1_d;
            dx1_q   <= dx1_d;
            dy1_q   <= dy1_d;
            dstx1_q <= dstx1_d;
            dsty1_q <= dsty1_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            pxc2_q  <= pxc2_d;
            pys2_q  <= pys2_d;
            pxs2_q  <= pxs2_d;
            pyc2_q  <= pyc2_d;
            dstx2_q <= dstx2_d;
            dsty2_q <= dsty2_d;
            last2_q <= last2_d;
            ov_q    <= ov_d;
            dstx3_q <= dstx3_d;
            dsty3_q <= dsty3_d;
            srcx3_q <= srcx3_d;
            srcy3_q <= srcy3_d;
            ir3_q   <= ir3_d;
            last3_q <= last3_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = ov_q;
    assign dst_x     = dstx3_q;
    assign dst_y     = dsty3_q;
    assign src_x     = srcx3_q;
    assign src_y     = srcy3_q;
    assign in_range  = ir3_q;
    assign out_last  = last3_q;

endmodule

// File: tb/tb_coord_rotate_scan.sv
// Bench for coord_rotate_scan on a reduced 16x12 image (centre 8,6).
// A reference model computes each beat's expected values from its raster index
// using plain integer floor division.
module tb_coord_rotate_scan;

    localparam int W   = 16;
    localparam int H   = 12;
    localparam int CXP = 8;
    localparam int CYP = 6;
    localparam int CW  = 12;
    localparam int TW  = 10;
    localparam int N   = W * H;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [TW-1:0] sin_val = '0;
    logic signed [TW-1:0] cos_val = '0;
    logic                 out_ready = 1'b1;
    logic                 busy, done, out_valid, in_range, out_last;
    logic        [CW-1:0] dst_x, dst_y;
    logic signed [CW-1:0] src_x, src_y;

    always #5 clk = ~clk;

    coord_rotate_scan #(
        .IMG_W(W), .IMG_H(H), .CX(CXP), .CY(CYP), .CW(CW), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sin_val(sin_val), .cos_val(cos_val),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .dst_x(dst_x), .dst_y(dst_y),
        .src_x(src_x), .src_y(src_y),
        .in_range(in_range), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int m_sin = 0, m_cos = 0;
    int exp_idx = 0, frame_beats = 0;
    bit hs_last_prev = 0, prev_stall = 0, saw_done = 0;
    bit rand_ready = 0;
    int last_ov = 0, last_busy = 0;
    int bsx[N], bsy[N], bir[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor256(input int a);
        if (a >= 0) return a / 256;
        return -((-a + 255) / 256);
    endfunction

    function automatic int wrap12(input int v);
        int r;
        r = v & 4095;
        if (r >= 2048) r = r - 4096;
        return r;
    endfunction

    function automatic int mdl_sx(input int idx);
        int dx, dy;
        dx = (idx % W) - CXP;
        dy = (idx / W) - CYP;
        return wrap12(floor256(dx * m_cos + dy * m_sin) + CXP);
    endfunction

    function automatic int mdl_sy(input int idx);
        int dx, dy;
        dx = (idx % W) - CXP;
        dy = (idx / W) - CYP;
        return wrap12(floor256(dy * m_cos - dx * m_sin) + CYP);
    endfunction

    // per-cycle comparison against the model, sampled at the falling edge
    task automatic monitor();
        int sx, sy, ir;
        bit lst;
        if (rst) begin
            exp_idx      = 0;
            frame_beats  = 0;
            hs_last_prev = 0;
            prev_stall   = 0;
        end else begin
            last_ov   = out_valid;
            last_busy = busy;
            chk("done", done, hs_last_prev);
            if (done) saw_done = 1;
            hs_last_prev = 0;
            if (start && !busy) begin
                m_sin       = sin_val;
                m_cos       = cos_val;
                exp_idx     = 0;
                frame_beats = 0;
            end
            if (prev_stall) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (exp_idx >= N) begin
                    chk("extra_beat", exp_idx, N - 1);
                end else begin
                    sx  = mdl_sx(exp_idx);
                    sy  = mdl_sy(exp_idx);
                    ir  = (sx >= 0 && sx < W && sy >= 0 && sy < H) ? 1 : 0;
                    lst = (exp_idx == N - 1);
                    chk("dst_x", dst_x, exp_idx % W);
                    chk("dst_y", dst_y, exp_idx / W);
                    chk("src_x", src_x, sx);
                    chk("src_y", src_y, sy);
                    chk("in_range", in_range, ir);
                    chk("out_last", out_last, lst);
                    if (out_ready) begin
                        bsx[exp_idx] = src_x;
                        bsy[exp_idx] = src_y;
                        bir[exp_idx] = in_range;
                        exp_idx++;
                        frame_beats++;
                        hs_last_prev = lst;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !saw_done; i++) cycle();
        if (!saw_done) chk("done_timeout", 0, 1);
    endtask

    task automatic begin_frame(input int s, input int c);
        sin_val  = s[TW-1:0];
        cos_val  = c[TW-1:0];
        saw_done = 0;
        start    = 1'b1;
        cycle();
        start    = 1'b0;
        // trig changes after the accepted start must not matter
        sin_val  = 10'sd77;
        cos_val  = -10'sd3;
    endtask

    initial begin
        // reset
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", {dst_x, dst_y, src_x, src_y} == '0 ? 1 : 0, 1);
        chk("rst_flags", {in_range, out_last}, 0);
        rst = 1'b0;
        cycle();

        // identity, latency check with ready high
        begin_frame(0, 256);
        cycle(); cycle(); cycle();
        chk("latency_pre", last_ov, 0);
        cycle();
        chk("latency_3", last_ov, 1);
        chk("busy_run", last_busy, 1);
        wait_done(4 * N + 50);
        chk("f1_beats", frame_beats, N);
        chk("f1_last_x", bsx[N-1], W - 1);
        chk("f1_last_y", bsy[N-1], H - 1);

        // 90 degrees, plus an ignored second start while busy
        begin_frame(256, 0);
        cycle();
        sin_val = 10'sd0;
        cos_val = 10'sd256;
        start   = 1'b1;
        cycle();
        start   = 1'b0;
        wait_done(4 * N + 50);
        chk("f2_beats", frame_beats, N);
        chk("f2_00_sx", bsx[0], 2);
        chk("f2_00_sy", bsy[0], 14);
        chk("f2_00_ir", bir[0], 0);
        chk("f2_c_sx", bsx[6*W+8], 8);
        chk("f2_c_sy", bsy[6*W+8], 6);
        chk("f2_c_ir", bir[6*W+8], 1);

        // 180 degrees
        begin_frame(0, -256);
        wait_done(4 * N + 50);
        chk("f3_beats", frame_beats, N);
        chk("f3_00_sx", bsx[0], 16);
        chk("f3_00_sy", bsy[0], 12);
        chk("f3_00_ir", bir[0], 0);
        chk("f3_11_sx", bsx[W+1], 15);
        chk("f3_11_sy", bsy[W+1], 11);
        chk("f3_11_ir", bir[W+1], 1);

        // 45 degrees with random backpressure
        rand_ready = 1;
        begin_frame(181, 181);
        wait_done(10 * N + 50);
        chk("f4_beats", frame_beats, N);
        chk("f4_87_sx", bsx[7*W+8], 8);
        chk("f4_87_sy", bsy[7*W+8], 6);
        chk("f4_85_sx", bsx[5*W+8], 7);
        chk("f4_85_sy", bsy[5*W+8], 5);

        // reset mid-frame, then rescan from (0,0)
        begin_frame(0, 256);
        repeat (40) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("midrst_busy", last_busy, 0);
        chk("midrst_valid", last_ov, 0);
        begin_frame(181, -181);
        wait_done(10 * N + 50);
        chk("f5_beats", frame_beats, N);
        rand_ready = 0;
        out_ready  = 1'b1;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
